// File: rtl/psw_pkg.sv
// psw_pkg: state encoding and width helpers for the parametrised password lock
package psw_pkg;
    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_PROGRAM = 3'd5
    } state_t;

    function automatic int fail_w(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    function automatic int idx_w(input int n_digits);
        return $clog2(n_digits + 1);
    endfunction

    function automatic int lock_w(input int lock_cycles);
        return lock_cycles < 2 ? 1 : $clog2(lock_cycles);
    endfunction
endpackage

// File: rtl/psw_press_edge.sv
// psw_press_edge: one-cycle press pulse on each rising edge of the debounced enter level
module psw_press_edge (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic press
);
    logic enter_q;

    always_ff @(posedge clk)
        enter_q <= rst ? 1'b0 : enter;

    assign press = enter & ~enter_q;
endmodule

// File: rtl/psw_lock_param.sv
// psw_lock_param: N-digit code lock with whole-sequence compare, timed lockout and reprogramming
module psw_lock_param
    import psw_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int N_DIGITS    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 50000000,
    parameter logic [DIGIT_W*N_DIGITS-1:0] DEFAULT_CODE = 16'h7117
) (
    input  logic                              MAX10_CLK1_50,
    input  logic                              RST,
    input  logic                              enter,
    input  logic [DIGIT_W-1:0]                digit,
    input  logic                              prog_mode,
    output logic                              unlocked,
    output logic                              alarm,
    output logic                              locked_out,
    output logic                              programming,
    output logic [fail_w(MAX_TRIES)-1:0]      fail_cnt,
    output logic [idx_w(N_DIGITS)-1:0]        digit_idx,
    output logic [2:0]                        state_o
);
    localparam int CW = DIGIT_W * N_DIGITS;
    localparam int FW = fail_w(MAX_TRIES);
    localparam int IW = idx_w(N_DIGITS);
    localparam int LW = lock_w(LOCK_CYCLES);

    state_t          state, state_n;
    logic [CW-1:0]   entry, entry_n, code, code_n;
    logic [IW-1:0]   idx_n;
    logic [FW-1:0]   fail_n;
    logic [LW-1:0]   cnt, cnt_n;
    logic            press;
    logic [CW-1:0]   shifted;

    psw_press_edge u_edge (
        .clk   (MAX10_CLK1_50),
        .rst   (RST),
        .enter (enter),
        .press (press)
    );

    assign shifted = (entry << DIGIT_W) | CW'(digit);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            state     <= S_ENTRY;
            entry     <= '0;
            code      <= DEFAULT_CODE;
            digit_idx <= '0;
            fail_cnt  <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            entry     <= entry_n;
            code      <= code_n;
            digit_idx <= idx_n;
            fail_cnt  <= fail_n;
            cnt       <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        entry_n = entry;
        code_n  = code;
        idx_n   = digit_idx;
        fail_n  = fail_cnt;
        cnt_n   = cnt;
        case (state)
            S_ENTRY: if (press) begin
                entry_n = shifted;
                idx_n   = digit_idx + IW'(1);
                state_n = idx_n == IW'(N_DIGITS) ? S_CHECK : S_ENTRY;
            end
            S_CHECK: begin
                idx_n   = '0;
                state_n = entry == code ? S_OPEN : S_FAIL;
                fail_n  = entry == code ? '0 : fail_cnt;
            end
            S_FAIL: begin
                fail_n  = fail_cnt + FW'(1);
                cnt_n   = LW'(LOCK_CYCLES - 1);
                state_n = fail_n == FW'(MAX_TRIES) ? S_LOCKOUT : S_ENTRY;
            end
            S_LOCKOUT: begin
                cnt_n   = cnt == '0 ? cnt : cnt - LW'(1);
                fail_n  = cnt == '0 ? '0 : fail_cnt;
                state_n = cnt == '0 ? S_ENTRY : S_LOCKOUT;
            end
            S_OPEN: if (press) state_n = prog_mode ? S_PROGRAM : S_ENTRY;
            S_PROGRAM:
                if (digit_idx == IW'(N_DIGITS)) begin
                    code_n  = entry;
                    idx_n   = '0;
                    state_n = S_ENTRY;
                end else if (press) begin
                    entry_n = shifted;
                    idx_n   = digit_idx + IW'(1);
                end
            default: state_n = S_ENTRY;
        endcase
    end

    assign unlocked    = state == S_OPEN;
    assign alarm       = state == S_FAIL;
    assign locked_out  = state == S_LOCKOUT;
    assign programming = state == S_PROGRAM;
    assign state_o     = state;
endmodule

// File: tb/tb_psw_lock_param.sv
// tb_psw_lock_param: directed self-checking bench for psw_lock_param with a 20-cycle lockout
module tb_psw_lock_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic [3:0] digit = '0;
    logic       prog_mode = 1'b0;
    logic       unlocked, alarm, locked_out, programming;
    logic [1:0] fail_cnt;
    logic [2:0] digit_idx, state_o;
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         lock_len;

    psw_lock_param #(.LOCK_CYCLES(20)) dut (
        .MAX10_CLK1_50 (clk),
        .RST           (rst),
        .enter         (enter),
        .digit         (digit),
        .prog_mode     (prog_mode),
        .unlocked      (unlocked),
        .alarm         (alarm),
        .locked_out    (locked_out),
        .programming   (programming),
        .fail_cnt      (fail_cnt),
        .digit_idx     (digit_idx),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic code4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(4'(c >> (4 * i)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", state_o, 0);
        check("rst_outs", {unlocked, alarm, locked_out, programming}, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_idx", digit_idx, 0);

        code4(16'h7117);
        check("ok_check_state", state_o, 1);
        check("ok_not_yet", unlocked, 0);
        @(negedge clk);
        check("ok_unlocked", unlocked, 1);
        check("ok_state", state_o, 2);
        check("ok_fail", fail_cnt, 0);

        press(4'd0);
        check("relock_unlocked", unlocked, 0);
        check("relock_state", state_o, 0);
        check("relock_fail", fail_cnt, 0);

        code4(16'h7116);
        check("bad_alarm_pre", alarm, 0);
        @(negedge clk);
        check("bad_alarm", alarm, 1);
        check("bad_unlocked", unlocked, 0);
        @(negedge clk);
        check("bad_alarm_end", alarm, 0);
        check("bad_fail", fail_cnt, 1);
        check("bad_state", state_o, 0);

        code4(16'h1234);
        repeat (2) @(negedge clk);
        check("bad2_fail", fail_cnt, 2);
        code4(16'h0000);
        @(negedge clk);
        check("bad3_alarm", alarm, 1);
        check("bad3_not_locked", locked_out, 0);
        @(negedge clk);
        lock_len = 0;
        digit = 4'd7;
        while (locked_out && lock_len < 100) begin
            lock_len++;
            enter = lock_len[0];
            @(negedge clk);
        end
        enter = 1'b0;
        check("lock_len", lock_len, 20);
        check("lock_idx", digit_idx, 0);
        check("lock_fail", fail_cnt, 0);
        check("lock_state", state_o, 0);
        @(negedge clk);
        code4(16'h7117);
        @(negedge clk);
        check("post_lock_unlock", unlocked, 1);

        prog_mode = 1'b1;
        press(4'd5);
        check("prog_on", programming, 1);
        check("prog_state", state_o, 5);
        check("prog_idx", digit_idx, 0);
        code4(16'h3392);
        check("prog_idx_full", digit_idx, 4);
        @(negedge clk);
        check("prog_done_state", state_o, 0);
        check("prog_done_off", programming, 0);
        prog_mode = 1'b0;
        code4(16'h7117);
        @(negedge clk);
        check("old_code_alarm", alarm, 1);
        @(negedge clk);
        code4(16'h3392);
        @(negedge clk);
        check("new_code_unlock", unlocked, 1);
        check("new_code_fail", fail_cnt, 0);

        press(4'd0);
        @(negedge clk);
        digit = 4'd7;
        enter = 1'b1;
        repeat (10) @(negedge clk);
        enter = 1'b0;
        check("held_idx", digit_idx, 1);
        press(4'd1);
        check("mid_idx", digit_idx, 2);
        digit = 4'd1;
        enter = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enter = 1'b0;
        check("midrst_idx", digit_idx, 0);
        check("midrst_state", state_o, 0);
        code4(16'h7117);
        @(negedge clk);
        check("midrst_default", unlocked, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
